// File: rtl/xrisc_mem_pkg.sv
// Shared types for the X-RISC data-memory controller.
//   dmem_state_t : controller FSM states
//   sb_entry_t   : one store-buffer entry (word address + data)
//   WORD_AW      : width of a word address (byte address bits [31:2])
package xrisc_mem_pkg;
  localparam int WORD_AW = 30;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } dmem_state_t;

  typedef struct packed {
    logic [WORD_AW-1:0] addr;
    logic [31:0]        data;
  } sb_entry_t;
endpackage

// File: rtl/xrisc_dmem_ctrl_if.sv
// Backing-memory port of the data-memory controller.
//   master : controller side (drives mem_req/mem_we/mem_addr/mem_wdata)
//   slave  : memory side (drives mem_gnt/mem_rvalid/mem_rdata)
interface xrisc_dmem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/xrisc_store_fifo.sv
// In-order store buffer: circular array with per-entry valid bits.
//   push_i/push_entry_i : enqueue at tail (ignored when full)
//   pop_i               : drop head (ignored when empty)
//   lkup_addr_i         : word address compared against all valid entries
//   head_o              : oldest entry
//   count_o/full_o/empty_o : occupancy
//   hit_o/hit_data_o    : any valid match, data of the youngest match
module xrisc_store_fifo
  import xrisc_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  sb_entry_t          push_entry_i,
  input  logic               pop_i,
  input  logic [WORD_AW-1:0] lkup_addr_i,
  output sb_entry_t          head_o,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               hit_o,
  output logic [31:0]        hit_data_o
);
  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = cnt_q;
  assign head_o  = ent_q[head_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer width equals log2(DEPTH), so increments wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      if (do_pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_push) ent_q[tail_q] <= push_entry_i;
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (ent_q[idx].addr == lkup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = ent_q[idx].data;
      end
    end
  end
endmodule

// File: rtl/xrisc_dmem_ctrl.sv
// Data-side memory controller for the X-RISC single-cycle core.
//   clk, reset              : clock, async active-low reset
//   MemWrite/MemRead        : core store / load request (store wins if both)
//   DataAdr/WriteData       : word address (bits [1:0] ignored) / store data
//   ReadData, Stall         : load result, core hold
//   buf_count               : store-buffer occupancy
//   mem                     : backing-memory port (master side)
// Stores are buffered and drained in order; loads forward from the buffer on
// a hit or stall for a memory read on a miss.
module xrisc_dmem_ctrl
  import xrisc_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [31:0]         DataAdr,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                Stall,
  output logic [CW-1:0]       buf_count,
  xrisc_dmem_ctrl_if.master   mem
);
  dmem_state_t        state_q, state_d;
  logic [WORD_AW-1:0] raddr_q, raddr_d;
  logic [31:0]        rdata_q, rdata_d;

  sb_entry_t   head, push_ent;
  logic        full, empty, fhit, store_acc, load, miss, pop;
  logic [31:0] fwd_data;
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^DataAdr[1:0];

  assign load      = MemRead & ~MemWrite;
  assign miss      = load & ~fhit;
  assign store_acc = MemWrite & ~full;
  assign pop       = (state_q == WR_REQ) & mem.mem_gnt;
  assign push_ent  = '{addr: DataAdr[31:2], data: WriteData};

  xrisc_store_fifo #(.DEPTH(DEPTH)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .push_i       (store_acc),
    .push_entry_i (push_ent),
    .pop_i        (pop),
    .lkup_addr_i  (DataAdr[31:2]),
    .head_o       (head),
    .count_o      (buf_count),
    .full_o       (full),
    .empty_o      (empty),
    .hit_o        (fhit),
    .hit_data_o   (fwd_data)
  );

  // Gated by reset so the core is never held while reset is asserted.
  assign Stall    = reset & ((MemWrite & full) | (miss & (state_q != RD_DONE)));
  assign ReadData = (load & fhit) ? fwd_data : rdata_q;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = RD_REQ;
          raddr_d = DataAdr[31:2];
        end else if (!empty || store_acc) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem.mem_gnt) begin
          if (miss) begin
            state_d = RD_REQ;
            raddr_d = DataAdr[31:2];
          end else if ((buf_count > CW'(1)) || store_acc) begin
            state_d = WR_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_REQ:  if (mem.mem_gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = mem.mem_rdata;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address is registered so mem_* decode only from state and buffer.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state_q)
      WR_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {head.addr, 2'b00};
        mem.mem_wdata = head.data;
      end
      RD_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {raddr_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_xrisc_dmem_ctrl.sv
// Directed test-plan steps followed by a randomized phase checked against an
// architectural memory model (last store in program order wins) and an
// in-order write-drain log.
module tb_xrisc_dmem_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic [2:0]  buf_count;

  xrisc_dmem_ctrl_if mif();

  // Memory-side drive: directed values or the random responder.
  bit          mem_auto = 1'b0;
  logic        dir_gnt = 1'b0, dir_rvalid = 1'b0;
  logic [31:0] dir_rdata = '0;
  logic        auto_gnt = 1'b0, auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0;
  assign mif.mem_gnt    = mem_auto ? auto_gnt    : dir_gnt;
  assign mif.mem_rvalid = mem_auto ? auto_rvalid : dir_rvalid;
  assign mif.mem_rdata  = mem_auto ? auto_rdata  : dir_rdata;

  xrisc_dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .buf_count (buf_count),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = w;
    MemRead   = r;
    DataAdr   = a;
    WriteData = d;
  endtask

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[15:0] ^ 16'h5A3C, ~w[15:0]};
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem_arr [logic [29:0]];  // backing memory contents
  logic [31:0] ref_mem [logic [29:0]];  // architectural view (program order)
  wr_t         wr_log [$];
  wr_t         st_q [$];

  // Random memory responder: decides grant/rvalid for the coming edge at
  // each falling edge, where mem_* are stable for the rest of the cycle.
  bit          rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [29:0] rd_w = '0;
  initial begin : memmodel
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        auto_rvalid = 1'b0;
        if (rd_pend) begin
          if (rd_cnt == 1) begin
            auto_rvalid = 1'b1;
            auto_rdata  = mem_arr.exists(rd_w) ? mem_arr[rd_w] : init_val(rd_w);
            rd_pend     = 1'b0;
          end else begin
            rd_cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          auto_rvalid = 1'b1;  // stray response, must be ignored
          auto_rdata  = $urandom;
        end
        auto_gnt = ($urandom_range(0, 9) < 4);
        if (mif.mem_req && auto_gnt) begin
          if (mif.mem_we) begin
            wr_log.push_back('{a: mif.mem_addr, d: mif.mem_wdata});
            mem_arr[mif.mem_addr[31:2]] = mif.mem_wdata;
          end else begin
            rd_pend = 1'b1;
            rd_cnt  = $urandom_range(1, 3);
            rd_w    = mif.mem_addr[31:2];
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          nstall;
    int          waited;
    int          op;
    bit          w, r;
    logic [31:0] a, d, exp;

    // 1. reset
    mid();
    chk("rst_in_stall", Stall, 0);
    chk("rst_in_req", mif.mem_req, 0);
    tick();
    reset = 1'b1;
    mid();
    chk("rst_stall", Stall, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_count", buf_count, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_addr", mif.mem_addr, 0);
    tick();

    // 2. single store drains with grant tied high
    dir_gnt = 1'b1;
    drv(1, 0, 32'h64, 32'd25);
    mid();
    chk("t2_nostall", Stall, 0);
    tick();
    drv(0, 0, 0, 0);
    mid();
    chk("t2_count1", buf_count, 1);
    chk("t2_req", mif.mem_req, 1);
    chk("t2_we", mif.mem_we, 1);
    chk("t2_addr", mif.mem_addr, 32'h64);
    chk("t2_wdata", mif.mem_wdata, 32'd25);
    tick();
    mid();
    chk("t2_count0", buf_count, 0);
    chk("t2_req_off", mif.mem_req, 0);
    tick();

    // 3. fill to DEPTH, stall on the fifth, drain in order
    dir_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 32'(4 * k), 32'(k + 1));
      mid();
      chk("t3_fill_nostall", Stall, 0);
      tick();
    end
    drv(1, 0, 32'h10, 32'd5);
    mid();
    chk("t3_full_stall", Stall, 1);
    chk("t3_full_count", buf_count, 4);
    chk("t3_head_addr", mif.mem_addr, 32'h0);
    chk("t3_head_data", mif.mem_wdata, 32'd1);
    dir_gnt = 1'b1;
    #1;
    chk("t3_pop_no_free", Stall, 1);
    tick();
    dir_gnt = 1'b0;
    mid();
    chk("t3_after_pop_stall", Stall, 0);
    chk("t3_after_pop_count", buf_count, 3);
    tick();
    drv(0, 0, 0, 0);
    mid();
    chk("t3_fifth_acc", buf_count, 4);
    dir_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t3_drain_addr", mif.mem_addr, 32'(4 * k));
      chk("t3_drain_data", mif.mem_wdata, 32'(k + 1));
      tick();
      mid();
    end
    chk("t3_drained", buf_count, 0);
    chk("t3_idle_req", mif.mem_req, 0);
    dir_gnt = 1'b0;
    tick();

    // 4. forwarding returns the youngest matching store
    drv(1, 0, 32'h60, 32'd7);
    tick();
    drv(1, 0, 32'h60, 32'd9);
    tick();
    drv(0, 1, 32'h63, 0);
    mid();
    chk("t4_fwd_data", ReadData, 32'd9);
    chk("t4_fwd_nostall", Stall, 0);
    chk("t4_count", buf_count, 2);
    tick();
    drv(0, 0, 0, 0);
    dir_gnt = 1'b1;
    tick();
    tick();
    mid();
    chk("t4_drained", buf_count, 0);
    dir_gnt = 1'b0;
    tick();

    // 5. load miss, grant same cycle, rvalid two cycles after grant
    nstall  = 0;
    dir_gnt = 1'b1;
    drv(0, 1, 32'h80, 0);
    mid();
    if (Stall) nstall++;
    chk("t5_c0_req", mif.mem_req, 0);
    tick();
    mid();
    if (Stall) nstall++;
    chk("t5_rd_req", mif.mem_req, 1);
    chk("t5_rd_we", mif.mem_we, 0);
    chk("t5_rd_addr", mif.mem_addr, 32'h80);
    tick();
    dir_gnt = 1'b0;
    mid();
    if (Stall) nstall++;
    chk("t5_wait_req", mif.mem_req, 0);
    tick();
    dir_rvalid = 1'b1;
    dir_rdata  = 32'hDEADBEEF;
    mid();
    if (Stall) nstall++;
    tick();
    dir_rvalid = 1'b0;
    mid();
    if (Stall) nstall++;
    chk("t5_release", Stall, 0);
    chk("t5_rdata", ReadData, 32'hDEADBEEF);
    chk("t5_stall_cycles", nstall, 4);
    tick();
    drv(0, 0, 0, 0);

    // 6. reset while in RD_WAIT with two stores buffered
    drv(1, 0, 32'h200, 32'hA);
    tick();
    drv(1, 0, 32'h204, 32'hB);
    tick();
    drv(1, 0, 32'h208, 32'hC);
    tick();
    drv(0, 1, 32'h300, 0);
    mid();
    chk("t6_miss_stall", Stall, 1);
    dir_gnt = 1'b1;
    tick();
    mid();
    chk("t6_rd_req", mif.mem_req, 1);
    chk("t6_rd_addr", mif.mem_addr, 32'h300);
    chk("t6_count2", buf_count, 2);
    tick();
    dir_gnt = 1'b0;
    mid();
    chk("t6_wait_req", mif.mem_req, 0);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_req", mif.mem_req, 0);
    chk("t6_rst_count", buf_count, 0);
    chk("t6_rst_stall", Stall, 0);
    chk("t6_rst_rdata", ReadData, 0);
    tick();
    drv(0, 0, 0, 0);
    dir_rvalid = 1'b1;
    dir_rdata  = 32'h12345678;
    tick();
    reset = 1'b1;
    mid();
    chk("t6_late_rvalid", ReadData, 0);
    tick();
    dir_rvalid = 1'b0;
    mid();
    chk("t6_late_rdata", ReadData, 0);
    chk("t6_late_req", mif.mem_req, 0);
    chk("t6_late_count", buf_count, 0);
    tick();

    // Randomized traffic against the architectural model
    mem_auto = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      d  = $urandom;
      w  = (op < 5);
      r  = (op >= 4) && (op < 9);  // op 4 drives both: the store wins
      drv(w, r, a, d);
      waited = 0;
      mid();
      while (Stall && waited < 100) begin
        tick();
        mid();
        waited++;
      end
      if (Stall) chk("rand_release", Stall, 0);
      if (r && !w) begin
        exp = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_val(a[31:2]);
        chk("rand_load", ReadData, exp);
      end
      if (w) begin
        ref_mem[a[31:2]] = d;
        st_q.push_back('{a: {a[31:2], 2'b00}, d: d});
      end
      tick();
    end
    drv(0, 0, 0, 0);
    waited = 0;
    mid();
    while ((buf_count != 0) && waited < 300) begin
      tick();
      mid();
      waited++;
    end
    chk("rand_drain_empty", buf_count, 0);
    chk("rand_write_count", wr_log.size(), st_q.size());
    for (int i = 0; i < st_q.size() && i < wr_log.size(); i++) begin
      chk("rand_wr_addr", wr_log[i].a, st_q[i].a);
      chk("rand_wr_data", wr_log[i].d, st_q[i].d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
